stage_ctrl: RTL and testbench



---
 rtl/stage_ctrl_if.sv | 33 +++
 rtl/stage_ctrl.sv | 143 ++++++++++++++
 tb/tb_stage_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/stage_ctrl_if.sv
// Control bundle between the stage sequencer and the datapath it steers.
// The sequencer takes the master side; the datapath and memory take the slave side.
interface stage_ctrl_if #(
  parameter int BEAT_W = 4
);
  logic              mem_inst;
  logic              mem_force;
  logic              mem_ready;
  logic              halt;
  logic              EXSTtoMEM_Wen;
  logic              IR_Wen;
  logic              PC_Wen;
  logic              PSR_Wen;
  logic              RF_Wen;
  logic              ST_Wen;
  logic [2:0]        stage;
  logic [BEAT_W-1:0] beat;
  logic              halted;
  logic              fault;
  logic              mem_timeout;

  modport master (
    input  mem_inst, mem_force, mem_ready, halt,
    output EXSTtoMEM_Wen, IR_Wen, PC_Wen, PSR_Wen, RF_Wen, ST_Wen,
    output stage, beat, halted, fault, mem_timeout
  );

  modport slave (
    output mem_inst, mem_force, mem_ready, halt,
    input  EXSTtoMEM_Wen, IR_Wen, PC_Wen, PSR_Wen, RF_Wen, ST_Wen,
    input  stage, beat, halted, fault, mem_timeout
  );
endinterface

// File: rtl/stage_ctrl.sv
// Multicycle IF/EXST/MEM sequencer with fetch/memory wait states, memory ready
// handshake, halt mode, sticky memory-timeout fault and a MEM->EXST beat counter.
module stage_ctrl #(
  parameter int IF_WAIT  = 0,
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4,
  parameter int TIMEOUT  = 0,
  parameter int TO_W     = 8,
  parameter int BEAT_W   = 4
) (
  input logic         clk,
  input logic         resetn,
  stage_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_EXST  = 3'd1,
    S_MEM   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [WAIT_W-1:0] IF_LIM  = WAIT_W'(IF_WAIT);
  localparam logic [WAIT_W-1:0] MEM_LIM = WAIT_W'(MEM_WAIT);
  localparam bit                TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0]   TO_LIM  = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wcnt, wcnt_nx;
  logic [TO_W-1:0]   tcnt, tcnt_nx;
  logic [BEAT_W-1:0] beat, beat_nx;
  logic              if_go;
  logic              mem_done;
  logic              mem_to;

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v,
                                                 input logic [WAIT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

  function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign if_go    = (wcnt == IF_LIM);
  assign mem_done = (wcnt == MEM_LIM) && bus.mem_ready;
  // Completion takes priority over a timeout landing in the same cycle.
  assign mem_to   = TO_EN && (tcnt == TO_LIM) && !mem_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IF;
      wcnt  <= '0;
      tcnt  <= '0;
      beat  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      tcnt  <= tcnt_nx;
      beat  <= beat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    tcnt_nx  = tcnt;
    beat_nx  = beat;
    case (state)
      S_IF: begin
        if (bus.halt) begin
          state_nx = S_HALT;
          beat_nx  = '0;
        end else if (if_go) begin
          state_nx = S_EXST;
          beat_nx  = '0;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      S_EXST: state_nx = bus.mem_inst ? S_MEM : S_IF;
      S_MEM: begin
        if (mem_done) begin
          state_nx = bus.mem_force ? S_EXST : S_IF;
          if (bus.mem_force) beat_nx = beat_inc(beat);
        end else if (mem_to) begin
          state_nx = S_FAULT;
        end else begin
          wcnt_nx = wait_inc(wcnt, MEM_LIM);
          tcnt_nx = tcnt + 1'b1;
        end
      end
      S_HALT:  if (!bus.halt) state_nx = S_IF;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IF;
    endcase
    if (state_nx != state) begin
      wcnt_nx = '0;
      tcnt_nx = '0;
    end
  end

  always_comb begin
    bus.EXSTtoMEM_Wen = 1'b0;
    bus.IR_Wen        = 1'b0;
    bus.PC_Wen        = 1'b0;
    bus.PSR_Wen       = 1'b0;
    bus.RF_Wen        = 1'b0;
    bus.ST_Wen        = 1'b0;
    bus.halted        = 1'b0;
    bus.fault         = 1'b0;
    bus.mem_timeout   = 1'b0;
    case (state)
      S_EXST: begin
        if (bus.mem_inst) begin
          bus.EXSTtoMEM_Wen = 1'b1;
        end else begin
          bus.PC_Wen  = 1'b1;
          bus.PSR_Wen = 1'b1;
          bus.RF_Wen  = 1'b1;
          bus.ST_Wen  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          bus.RF_Wen = 1'b1;
          bus.ST_Wen = 1'b1;
          bus.PC_Wen = !bus.mem_force;
        end
        bus.mem_timeout = mem_to;
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault  = 1'b1;
      // IF and any unused encoding fetch the same way.
      default: bus.IR_Wen = !bus.halt && if_go;
    endcase
  end

  assign bus.stage = state;
  assign bus.beat  = beat;

endmodule

// File: tb/tb_stage_ctrl.sv
// Randomized scoreboard bench for stage_ctrl: two configurations run side by side,
// expected cycles are derived from instruction-level timing rules.
module tb_stage_ctrl;

  localparam int A_IFW = 0, A_MW = 0, A_TO = 0, A_BW = 4;
  localparam int B_IFW = 2, B_MW = 1, B_TO = 5, B_BW = 2;

  logic clk    = 1'b0;
  logic rstn_a = 1'b0;
  logic rstn_b = 1'b0;
  always #5 clk = ~clk;

  stage_ctrl_if #(.BEAT_W(A_BW)) ifa ();
  stage_ctrl_if #(.BEAT_W(B_BW)) ifb ();

  stage_ctrl #(.IF_WAIT(A_IFW), .MEM_WAIT(A_MW), .WAIT_W(4), .TIMEOUT(A_TO), .TO_W(8),
               .BEAT_W(A_BW)) dut_a (.clk(clk), .resetn(rstn_a), .bus(ifa));
  stage_ctrl #(.IF_WAIT(B_IFW), .MEM_WAIT(B_MW), .WAIT_W(3), .TIMEOUT(B_TO), .TO_W(4),
               .BEAT_W(B_BW)) dut_b (.clk(clk), .resetn(rstn_b), .bus(ifb));

  // en = {EXSTtoMEM, IR, PC, PSR, RF, ST}
  typedef struct packed {
    logic       rst_n, mi, mf, mr, h;
    logic [5:0] en;
    logic [2:0] stg;
    logic [3:0] bt;
    logic       hd, ft, mto;
  } cyc_t;

  cyc_t gq[$], stim_a[$], stim_b[$], exp_a[$], exp_b[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rn, input logic mi, input logic mf, input logic mr,
                      input logic h, input logic [5:0] en, input logic [2:0] stg,
                      input int bt, input logic hd, input logic ft, input logic mto);
    cyc_t c;
    c.rst_n = rn; c.mi = mi; c.mf = mf; c.mr = mr; c.h = h;
    c.en = en; c.stg = stg; c.bt = 4'(bt); c.hd = hd; c.ft = ft; c.mto = mto;
    gq.push_back(c);
  endtask

  // A cycle spent with resetn low: IF with cleared counters, nothing advances.
  task automatic push_rst(input int ifw);
    logic h;
    h = rbit();
    push(1'b0, rbit(), rbit(), rbit(), h, (ifw == 0 && !h) ? 6'b010000 : 6'b000000,
         3'd0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Builds the cycle-by-cycle schedule for ninst random instructions.
  task automatic gen(input int ifw, input int mw, input int to, input int bmax,
                     input int ninst);
    int bt;
    bt = 0;
    push_rst(ifw);
    for (int i = 0; i < ninst; i++) begin
      bit done;
      int loops;
      if ($urandom_range(0, 4) == 0) begin
        int j;
        j = $urandom_range(0, ifw);
        for (int c = 0; c < j; c++)
          push(1'b1, rbit(), rbit(), rbit(), 1'b0, 6'b0, 3'd0, bt, 1'b0, 1'b0, 1'b0);
        push(1'b1, rbit(), rbit(), rbit(), 1'b1, 6'b0, 3'd0, bt, 1'b0, 1'b0, 1'b0);
        bt = 0;
        for (int c = $urandom_range(0, 3); c > 0; c--)
          push(1'b1, rbit(), rbit(), rbit(), 1'b1, 6'b0, 3'd3, 0, 1'b1, 1'b0, 1'b0);
        push(1'b1, rbit(), rbit(), rbit(), 1'b0, 6'b0, 3'd3, 0, 1'b1, 1'b0, 1'b0);
      end
      for (int c = 0; c <= ifw; c++)
        push(1'b1, rbit(), rbit(), rbit(), 1'b0, (c == ifw) ? 6'b010000 : 6'b000000,
             3'd0, bt, 1'b0, 1'b0, 1'b0);
      bt = 0;
      done = 1'b0;
      loops = 0;
      while (!done) begin
        logic mi;
        mi = (loops > 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) != 0);
        if (!mi) begin
          push(1'b1, 1'b0, rbit(), rbit(), rbit(), 6'b001111, 3'd1, bt, 1'b0, 1'b0, 1'b0);
          done = 1'b1;
        end else begin
          int mode, k;
          bit in_mem;
          push(1'b1, 1'b1, rbit(), rbit(), rbit(), 6'b100000, 3'd1, bt, 1'b0, 1'b0, 1'b0);
          mode = $urandom_range(0, 7);
          k = 1;
          in_mem = 1'b1;
          while (in_mem) begin
            logic mr, mf;
            bit comp;
            if ($urandom_range(0, 39) == 0) begin
              push_rst(ifw);
              bt = 0; done = 1'b1; in_mem = 1'b0;
            end else begin
              if (mode == 0)      mr = (to == 0 && k > 6);
              else if (mode == 1) mr = (k >= ((to == 0) ? 4 : to));
              else                mr = ($urandom_range(0, 3) != 0);
              comp = (k - 1 >= mw) && mr;
              if (comp) begin
                mf = (loops < 5) && rbit();
                push(1'b1, rbit(), mf, mr, rbit(), {2'b00, !mf, 1'b0, 2'b11}, 3'd2, bt,
                     1'b0, 1'b0, 1'b0);
                in_mem = 1'b0;
                if (mf) begin
                  bt = (bt < bmax) ? bt + 1 : bt;
                  loops++;
                end else begin
                  done = 1'b1;
                end
              end else if (to != 0 && k == to) begin
                push(1'b1, rbit(), rbit(), mr, rbit(), 6'b0, 3'd2, bt, 1'b0, 1'b0, 1'b1);
                for (int f = $urandom_range(1, 4); f > 0; f--)
                  push(1'b1, rbit(), rbit(), rbit(), rbit(), 6'b0, 3'd4, bt, 1'b0, 1'b1, 1'b0);
                push_rst(ifw);
                bt = 0; in_mem = 1'b0; done = 1'b1;
              end else begin
                push(1'b1, rbit(), rbit(), mr, rbit(), 6'b0, 3'd2, bt, 1'b0, 1'b0, 1'b0);
                k++;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic drive_a();
    while (stim_a.size() > 0) begin
      cyc_t c;
      c = stim_a.pop_front();
      @(posedge clk);
      #1;
      ifa.mem_inst = c.mi; ifa.mem_force = c.mf; ifa.mem_ready = c.mr; ifa.halt = c.h;
      rstn_a = c.rst_n;
      exp_a.push_back(c);
    end
  endtask

  task automatic drive_b();
    while (stim_b.size() > 0) begin
      cyc_t c;
      c = stim_b.pop_front();
      @(posedge clk);
      #1;
      ifb.mem_inst = c.mi; ifb.mem_force = c.mf; ifb.mem_ready = c.mr; ifb.halt = c.h;
      rstn_b = c.rst_n;
      exp_b.push_back(c);
    end
  endtask

  task automatic check(input string nm, input cyc_t e, input logic [5:0] en,
                       input logic [2:0] stg, input logic [3:0] bt, input logic hd,
                       input logic ft, input logic mto);
    n_chk++;
    if ({en, stg, bt, hd, ft, mto} === {e.en, e.stg, e.bt, e.hd, e.ft, e.mto}) begin
      n_pass++;
    end else begin
      $display("FAIL %s check %0d: got en=%b stage=%0d beat=%0d halted=%b fault=%b to=%b; want en=%b stage=%0d beat=%0d halted=%b fault=%b to=%b",
               nm, n_chk, en, stg, bt, hd, ft, mto, e.en, e.stg, e.bt, e.hd, e.ft, e.mto);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle.
  always @(negedge clk) begin
    if (exp_a.size() > 0)
      check("cfgA", exp_a.pop_front(),
            {ifa.EXSTtoMEM_Wen, ifa.IR_Wen, ifa.PC_Wen, ifa.PSR_Wen, ifa.RF_Wen, ifa.ST_Wen},
            ifa.stage, 4'(ifa.beat), ifa.halted, ifa.fault, ifa.mem_timeout);
    if (exp_b.size() > 0)
      check("cfgB", exp_b.pop_front(),
            {ifb.EXSTtoMEM_Wen, ifb.IR_Wen, ifb.PC_Wen, ifb.PSR_Wen, ifb.RF_Wen, ifb.ST_Wen},
            ifb.stage, 4'(ifb.beat), ifb.halted, ifb.fault, ifb.mem_timeout);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.mem_inst = 1'b0; ifa.mem_force = 1'b0; ifa.mem_ready = 1'b0; ifa.halt = 1'b0;
    ifb.mem_inst = 1'b0; ifb.mem_force = 1'b0; ifb.mem_ready = 1'b0; ifb.halt = 1'b0;
    gen(A_IFW, A_MW, A_TO, (1 << A_BW) - 1, 150);
    stim_a = gq;
    gq.delete();
    gen(B_IFW, B_MW, B_TO, (1 << B_BW) - 1, 150);
    stim_b = gq;
    gq.delete();
    fork
      drive_a();
      drive_b();
    join
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_a.size() == 0 && exp_b.size() == 0) n_pass++;
    else $display("FAIL drain: %0d/%0d expected cycles left unchecked, required 0/0",
                  exp_a.size(), exp_b.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
